// File: rtl/reg_bank_writer.sv
// Write side of the register bank: single-port update of NUM_REGS words with
// load / immediate / increment / decrement, plus a per-register dirty mask.
module reg_bank_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 9,
    parameter int SEL_WIDTH  = 4,
    parameter int IMM_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [SEL_WIDTH-1:0]           wr_sel,
    input  logic [1:0]                     wr_op,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [IMM_WIDTH-1:0]           wr_imm,
    input  logic [NUM_REGS-1:0]            clr_dirty,
    output logic [NUM_REGS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_REGS-1:0]            dirty,
    output logic                           wr_ack,
    output logic                           wr_err
);

    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0] bank_r [NUM_REGS];
    logic [NUM_REGS-1:0]   dirty_r;
    logic                  ack_r;
    logic                  err_r;

    logic                  legal_s;
    logic [DATA_WIDTH-1:0] cur_s;
    logic [DATA_WIDTH-1:0] next_s;
    logic [NUM_REGS-1:0]   commit_s;

    // Decode the request: legality, current operand, new value and per-register commit strobes
    always_comb begin
        legal_s  = (wr_sel <= LAST_SEL);
        cur_s    = '0;
        next_s   = '0;
        commit_s = '0;
        if (legal_s) begin
            cur_s = bank_r[wr_sel];
        end else begin
            cur_s = '0;
        end
        case (wr_op)
            2'b00:   next_s = wr_data;
            2'b01:   next_s = {{(DATA_WIDTH-IMM_WIDTH){wr_imm[IMM_WIDTH-1]}}, wr_imm};
            2'b10:   next_s = cur_s + DATA_WIDTH'(1);
            2'b11:   next_s = cur_s - DATA_WIDTH'(1);
            default: next_s = cur_s;
        endcase
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_en && legal_s && (wr_sel == SEL_WIDTH'(k))) begin
                commit_s[k] = 1'b1;
            end else begin
                commit_s[k] = 1'b0;
            end
        end
    end

    // Bank, dirty mask and response pulses; set beats clear on the same register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                bank_r[k] <= '0;
            end
            dirty_r <= '0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit_s[k]) begin
                    bank_r[k] <= next_s;
                end
            end
            dirty_r <= (dirty_r & ~clr_dirty) | commit_s;
            ack_r   <= wr_en & legal_s;
            err_r   <= wr_en & ~legal_s;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign data_out[DATA_WIDTH*g +: DATA_WIDTH] = bank_r[g];
    end

    assign dirty  = dirty_r;
    assign wr_ack = ack_r;
    assign wr_err = err_r;

endmodule

// File: tb/tb_reg_bank_writer.sv
// Randomized and directed bench for reg_bank_writer against an array-based reference model.
module tb_reg_bank_writer;

    localparam int DW = 16;
    localparam int NR = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [3:0]      wr_sel;
    logic [1:0]      wr_op;
    logic [DW-1:0]   wr_data;
    logic [7:0]      wr_imm;
    logic [NR-1:0]   clr_dirty;
    logic [NR*DW-1:0] data_out;
    logic [NR-1:0]   dirty;
    logic            wr_ack;
    logic            wr_err;

    int checks = 0;
    int errors = 0;

    int           m_reg [NR];
    logic [NR-1:0] m_dirty;
    logic          m_ack;
    logic          m_err;

    reg_bank_writer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_op(wr_op),
        .wr_data(wr_data), .wr_imm(wr_imm), .clr_dirty(clr_dirty),
        .data_out(data_out), .dirty(dirty), .wr_ack(wr_ack), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_bus();
        logic [NR*DW-1:0] b;
        b = '0;
        for (int k = 0; k < NR; k++) begin
            b[DW*k +: DW] = m_reg[k][DW-1:0];
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) m_reg[k] = 0;
        m_dirty = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, data_out, model_bus());
        check({tag, ".dirty"}, {135'd0, dirty}, {135'd0, m_dirty});
        check({tag, ".wr_ack"}, {143'd0, wr_ack}, {143'd0, m_ack});
        check({tag, ".wr_err"}, {143'd0, wr_err}, {143'd0, m_err});
    endtask

    // One clocked request: drive, update model at the edge, check 1 time unit later
    task automatic step(input string tag, input logic en, input int sel, input int op,
                        input int data, input int imm, input logic [NR-1:0] clr);
        int v;
        wr_en = en; wr_sel = sel[3:0]; wr_op = op[1:0];
        wr_data = data[DW-1:0]; wr_imm = imm[7:0]; clr_dirty = clr;
        @(posedge clk);
        m_ack = 1'b0;
        m_err = 1'b0;
        m_dirty = m_dirty & ~clr;
        if (en) begin
            if (sel < NR) begin
                case (op)
                    0: v = data % 65536;
                    1: v = (imm >= 128) ? (imm - 256 + 65536) : imm;
                    2: v = (m_reg[sel] + 1) % 65536;
                    default: v = (m_reg[sel] + 65535) % 65536;
                endcase
                m_reg[sel] = v;
                m_dirty[sel] = 1'b1;
                m_ack = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        wr_en = 1'b0; clr_dirty = '0;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_op = '0;
        wr_data = '0; wr_imm = '0; clr_dirty = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst = 1'b0;

        step("load3", 1'b1, 3, 0, 32'hBEEF, 0, '0);
        check("load3.word", {128'd0, data_out[63:48]}, {128'd0, 16'hBEEF});
        step("idle", 1'b0, 3, 0, 0, 0, '0);
        step("imm8", 1'b1, 8, 1, 0, 8'h80, '0);
        check("imm8.word", {128'd0, data_out[143:128]}, {128'd0, 16'hFF80});
        step("imm0", 1'b1, 0, 1, 0, 8'h7F, '0);
        check("imm0.word", {128'd0, data_out[15:0]}, {128'd0, 16'h007F});
        step("wrap.load", 1'b1, 5, 0, 32'hFFFF, 0, '0);
        step("wrap.inc", 1'b1, 5, 2, 0, 0, '0);
        step("wrap.dec1", 1'b1, 5, 3, 0, 0, '0);
        step("wrap.dec2", 1'b1, 5, 3, 0, 0, '0);
        check("wrap.word", {128'd0, data_out[95:80]}, {128'd0, 16'hFFFE});
        step("illegal9", 1'b1, 9, 0, 32'h1234, 0, '0);
        step("illegal15", 1'b1, 15, 2, 0, 0, '0);
        step("race.set", 1'b1, 2, 0, 32'h0055, 0, '0);
        step("race.set1", 1'b1, 1, 0, 32'h0011, 0, '0);
        step("race", 1'b1, 2, 2, 0, 0, 9'b000000110);
        check("race.bits", {142'd0, dirty[2:1]}, {142'd0, 2'b10});
        step("inc.b2b1", 1'b1, 7, 2, 0, 0, '0);
        step("inc.b2b2", 1'b1, 7, 2, 0, 0, '0);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) < 8), $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 65535), $urandom_range(0, 255),
                 ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0);
        end

        // Asynchronous reset in the middle of a cycle with a request pending
        wr_en = 1'b1; wr_sel = 4'd4; wr_op = 2'b00; wr_data = 16'h5A5A;
        #3 rst = 1'b1;
        model_reset();
        #1 check_all("midrst");
        @(posedge clk);
        #1 wr_en = 1'b0;
        check_all("midrst.hold");
        @(negedge clk) rst = 1'b0;
        step("postrst", 1'b0, 0, 0, 0, 0, '0);
        step("postrst.load", 1'b1, 6, 0, 32'hA5A5, 0, 9'h1FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
